// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for a multi-cycle MIPS datapath that has one memory and one
// ALU. It steps each instruction through FETCH / DECODE / execute / memory /
// writeback states. It supports R-type, addi, andi, lw, sw, beq, bne and j.
// Memory accesses wait for mem_ready. If a memory wait lasts too long, the
// FSM stops in a sticky FAULT state.
//
// Parameters
//   MEM_TIMEOUT  number of consecutive not-ready cycles in a memory wait
//                state before FAULT (0 = never time out)
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   opcode[5:0]           IR[31:26]
//   mem_ready             memory completes the current access this cycle
//   PCWrite .. Bne        single-bit datapath strobes (Moore, state decoded)
//   ALUSrcB[1:0]          00 rt, 01 const 4, 10 signext imm, 11 imm<<2
//   ALUOp[1:0]            00 add, 01 sub, 10 funct-decoded, 11 and
//   PCSource[1:0]         00 ALU result, 01 ALUOut, 10 jump target
//   state[3:0]            current FSM state encoding
//   instr_done            high while the last state of an instruction is active
//   illegal_op            high in DECODE when the opcode is undefined
//   fault                 sticky memory-timeout flag
//   seg_first..seg_fifth  active-low 7-segment digits, bit order gfedcba
//
// Build option
//   STATE_SEG_EN  when defined, the seg_* outputs show a short state name.
//                 The value is registered one cycle behind state.
//                 When undefined, all digits are tied blank.
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       Bne,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       fault,
    output logic [6:0] seg_first,
    output logic [6:0] seg_second,
    output logic [6:0] seg_third,
    output logic [6:0] seg_fourth,
    output logic [6:0] seg_fifth
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_FAULT  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // The counter only needs to reach MEM_TIMEOUT-1. It is cleared on the
    // cycle it would time out, so it never wraps.
    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_next;
    logic             r_fault;
    logic             w_wait_state;
    logic             w_timeout;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                          (r_state == S_MEMWR);

    // A ready memory on the last allowed cycle still advances normally.
    assign w_timeout = (MEM_TIMEOUT != 0) && w_wait_state && !mem_ready &&
                       (r_wait_cnt == CNT_LAST);

    // The counter counts only while the FSM stays in the same wait state.
    // Any state change or a ready memory restarts it from zero.
    always_comb begin
        w_wait_cnt_next = '0;
        if ((MEM_TIMEOUT != 0) && w_wait_state && !mem_ready &&
            (w_state_next == r_state))
            w_wait_cnt_next = r_wait_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_fault    <= r_fault | (w_state_next == S_FAULT);
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_state_next = r_state;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        MemtoReg     = 1'b0;
        RegDst       = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        Bne          = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        PCSource     = 2'b00;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;

        case (r_state)
            S_IDLE: w_state_next = S_FETCH;

            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready)      w_state_next = S_DECODE;
                else if (w_timeout) w_state_next = S_FAULT;
            end

            S_DECODE: begin
                // The branch target is precomputed here, while the ALU is idle.
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:        w_state_next = S_EXEC;
                    OP_ADDI, OP_ANDI: w_state_next = S_IMMEX;
                    OP_LW, OP_SW:    w_state_next = S_MEMADR;
                    OP_BEQ, OP_BNE:  w_state_next = S_BRANCH;
                    OP_J:            w_state_next = S_JUMP;
                    default: begin
                        w_state_next = S_FETCH;
                        illegal_op   = 1'b1;
                    end
                endcase
            end

            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready)      w_state_next = S_MEMWB;
                else if (w_timeout) w_state_next = S_FAULT;
            end

            S_MEMWB: begin
                MemtoReg     = 1'b1;
                RegWrite     = 1'b1;
                instr_done   = 1'b1;
                w_state_next = S_FETCH;
            end

            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready)      w_state_next = S_FETCH;
                else if (w_timeout) w_state_next = S_FAULT;
            end

            S_EXEC: begin
                ALUSrcA      = 1'b1;
                ALUOp        = 2'b10;
                w_state_next = S_ALUWB;
            end

            S_ALUWB: begin
                RegDst       = 1'b1;
                RegWrite     = 1'b1;
                instr_done   = 1'b1;
                w_state_next = S_FETCH;
            end

            S_IMMEX: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ALUOp        = (opcode == OP_ANDI) ? 2'b11 : 2'b00;
                w_state_next = S_IMMWB;
            end

            S_IMMWB: begin
                RegWrite     = 1'b1;
                instr_done   = 1'b1;
                w_state_next = S_FETCH;
            end

            S_BRANCH: begin
                // beq and bne differ only in opcode bit 0.
                ALUSrcA      = 1'b1;
                ALUOp        = 2'b01;
                PCWriteCond  = 1'b1;
                PCSource     = 2'b01;
                Bne          = opcode[0];
                instr_done   = 1'b1;
                w_state_next = S_FETCH;
            end

            S_JUMP: begin
                PCWrite      = 1'b1;
                PCSource     = 2'b10;
                instr_done   = 1'b1;
                w_state_next = S_FETCH;
            end

            S_FAULT: w_state_next = S_FAULT;

            default: w_state_next = S_IDLE;
        endcase
    end

    assign state = r_state;
    assign fault = r_fault;

`ifdef STATE_SEG_EN
    // Active-low glyphs, bit order gfedcba
    localparam logic [6:0] CH_BL = 7'b1111111;
    localparam logic [6:0] CH_A  = 7'b0001000;
    localparam logic [6:0] CH_b  = 7'b0000011;
    localparam logic [6:0] CH_C  = 7'b1000110;
    localparam logic [6:0] CH_d  = 7'b0100001;
    localparam logic [6:0] CH_E  = 7'b0000110;
    localparam logic [6:0] CH_F  = 7'b0001110;
    localparam logic [6:0] CH_h  = 7'b0001011;
    localparam logic [6:0] CH_I  = 7'b1111001;
    localparam logic [6:0] CH_J  = 7'b1100001;
    localparam logic [6:0] CH_L  = 7'b1000111;
    localparam logic [6:0] CH_P  = 7'b0001100;
    localparam logic [6:0] CH_r  = 7'b0101111;
    localparam logic [6:0] CH_S  = 7'b0010010;
    localparam logic [6:0] CH_t  = 7'b0000111;
    localparam logic [6:0] CH_U  = 7'b1000001;
    localparam logic [6:0] CH_X  = 7'b0001001;

    function automatic logic [34:0] seg_text(input state_t s);
        case (s)
            S_IDLE:   seg_text = {CH_I, CH_d, CH_L, CH_E, CH_BL};
            S_FETCH:  seg_text = {CH_F, CH_E, CH_t, CH_C, CH_h};
            S_DECODE: seg_text = {CH_d, CH_E, CH_C, CH_BL, CH_BL};
            S_MEMADR: seg_text = {CH_A, CH_d, CH_d, CH_r, CH_BL};
            S_MEMRD:  seg_text = {CH_r, CH_d, CH_BL, CH_BL, CH_BL};
            S_MEMWB:  seg_text = {CH_L, CH_d, CH_b, CH_BL, CH_BL};
            S_MEMWR:  seg_text = {CH_S, CH_t, CH_BL, CH_BL, CH_BL};
            S_EXEC:   seg_text = {CH_E, CH_X, CH_E, CH_BL, CH_BL};
            S_ALUWB:  seg_text = {CH_A, CH_L, CH_U, CH_b, CH_BL};
            S_IMMEX:  seg_text = {CH_I, CH_E, CH_X, CH_BL, CH_BL};
            S_IMMWB:  seg_text = {CH_I, CH_b, CH_BL, CH_BL, CH_BL};
            S_BRANCH: seg_text = {CH_b, CH_r, CH_BL, CH_BL, CH_BL};
            S_JUMP:   seg_text = {CH_J, CH_P, CH_BL, CH_BL, CH_BL};
            S_FAULT:  seg_text = {CH_F, CH_A, CH_U, CH_L, CH_t};
            default:  seg_text = {5{CH_BL}};
        endcase
    endfunction

    logic [34:0] r_seg;

    always_ff @(posedge clk) begin
        if (reset) r_seg <= {35{1'b1}};
        else       r_seg <= seg_text(r_state);
    end

    assign {seg_first, seg_second, seg_third, seg_fourth, seg_fifth} = r_seg;
`else
    assign seg_first  = 7'b1111111;
    assign seg_second = 7'b1111111;
    assign seg_third  = 7'b1111111;
    assign seg_fourth = 7'b1111111;
    assign seg_fifth  = 7'b1111111;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Self-checking bench for multicycle_control, built with MEM_TIMEOUT=4.
// Stimulus comes from a vector table of {reset, opcode, mem_ready, expected
// state}. The expected strobes are derived from the expected state by the
// bench's own decode model.
//
// Each cycle the bench drives the inputs and pushes the expected record into
// a scoreboard queue. It then samples the DUT on the falling edge, pops the
// record and compares. Hand-written sequences after the table cover the
// timeouts and a reset during a store.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Bne;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic       instr_done, illegal_op, fault;
    logic [6:0] seg_first, seg_second, seg_third, seg_fourth, seg_fifth;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .Bne        (Bne),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSource   (PCSource),
        .state      (state),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .fault      (fault),
        .seg_first  (seg_first),
        .seg_second (seg_second),
        .seg_third  (seg_third),
        .seg_fourth (seg_fourth),
        .seg_fifth  (seg_fifth)
    );

    // Packed observation vector; the model builds the same field order.
    logic [19:0] act;
    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, Bne,
                  ALUSrcB, ALUOp, PCSource, instr_done, illegal_op, fault};

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
    } vec_t;

    typedef struct packed {
        logic [3:0]  st;
        logic [19:0] outs;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference decode: expected strobes for a given (expected) state.
    function automatic logic [19:0] model(input logic [3:0] st,
                                          input logic [5:0] op,
                                          input logic rdy);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        logic m2r = 0, rdst = 0, rw = 0, srca = 0, bne = 0;
        logic [1:0] srcb = 2'b00, aop = 2'b00, pcs = 2'b00;
        logic done = 0, ill = 0, flt = 0;
        case (st)
            4'd1: begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            4'd2: begin
                srcb = 2'b11;
                ill = !(op == 6'h00 || op == 6'h08 || op == 6'h0C ||
                        op == 6'h23 || op == 6'h2B || op == 6'h04 ||
                        op == 6'h05 || op == 6'h02);
            end
            4'd3:  begin srca = 1; srcb = 2'b10; end
            4'd4:  begin mrd = 1; iord = 1; end
            4'd5:  begin m2r = 1; rw = 1; done = 1; end
            4'd6:  begin mwr = 1; iord = 1; done = rdy; end
            4'd7:  begin srca = 1; aop = 2'b10; end
            4'd8:  begin rdst = 1; rw = 1; done = 1; end
            4'd9:  begin srca = 1; srcb = 2'b10; aop = (op == 6'h0C) ? 2'b11 : 2'b00; end
            4'd10: begin rw = 1; done = 1; end
            4'd11: begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; bne = op[0]; done = 1; end
            4'd12: begin pcw = 1; pcs = 2'b10; done = 1; end
            4'd15: flt = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, bne,
                srcb, aop, pcs, done, ill, flt};
    endfunction

    function automatic void add(input logic rst, input logic [5:0] op,
                                input logic rdy, input logic [3:0] st);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.st = st;
        vecs.push_back(v);
    endfunction

    task automatic check_cycle(input string tag);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s scoreboard: got empty queue, want one entry", tag);
        end else begin
            e = sb.pop_front();
            if (state !== e.st) begin
                n_bad++;
                $display("FAIL %s state: got %0d, want %0d", tag, state, e.st);
            end
            n_cmp++;
            if (act !== e.outs) begin
                n_bad++;
                $display("FAIL %s strobes(st=%0d): got %05h, want %05h",
                         tag, e.st, act, e.outs);
            end
            $display("%s: rst=%0b op=%02h rdy=%0b state=%0d strobes=%05h",
                     tag, reset, opcode, mem_ready, state, act);
        end
    endtask

    // One transaction: drive, push expectation, sample on falling edge,
    // then advance past the rising edge.
    task automatic apply(input logic rst, input logic [5:0] op,
                         input logic rdy, input logic [3:0] st,
                         input string tag);
        exp_t e;
        reset     = rst;
        opcode    = op;
        mem_ready = rdy;
        e.st   = st;
        e.outs = model(st, op, rdy);
        sb.push_back(e);
        @(negedge clk);
        check_cycle(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = 6'h00; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Displays are blank while reset is held, with or without the option.
        @(negedge clk);
        n_cmp++;
        if ({seg_first, seg_second, seg_third, seg_fourth, seg_fifth} !== {35{1'b1}}) begin
            n_bad++;
            $display("FAIL seg_reset: got %09h, want %09h",
                     {seg_first, seg_second, seg_third, seg_fourth, seg_fifth}, {35{1'b1}});
        end
        @(posedge clk);
        #1;

        // ---- vector table ----
        add(1, 6'h00, 1, 0);
        add(0, 6'h00, 1, 0);
        // R-type: 1,2,7,8
        add(0, 6'h00, 1, 1); add(0, 6'h00, 1, 2); add(0, 6'h00, 1, 7); add(0, 6'h00, 1, 8);
        // addi / andi
        add(0, 6'h08, 1, 1); add(0, 6'h08, 1, 2); add(0, 6'h08, 1, 9); add(0, 6'h08, 1, 10);
        add(0, 6'h0C, 1, 1); add(0, 6'h0C, 1, 2); add(0, 6'h0C, 1, 9); add(0, 6'h0C, 1, 10);
        // lw with three not-ready cycles in MEMRD
        add(0, 6'h23, 1, 1); add(0, 6'h23, 1, 2); add(0, 6'h23, 1, 3);
        for (int i = 0; i < 3; i++) add(0, 6'h23, 0, 4);
        add(0, 6'h23, 1, 4); add(0, 6'h23, 1, 5);
        // sw ready, then sw with two not-ready cycles
        add(0, 6'h2B, 1, 1); add(0, 6'h2B, 1, 2); add(0, 6'h2B, 1, 3); add(0, 6'h2B, 1, 6);
        add(0, 6'h2B, 1, 1); add(0, 6'h2B, 1, 2); add(0, 6'h2B, 1, 3);
        add(0, 6'h2B, 0, 6); add(0, 6'h2B, 0, 6); add(0, 6'h2B, 1, 6);
        // beq / bne
        add(0, 6'h04, 1, 1); add(0, 6'h04, 1, 2); add(0, 6'h04, 1, 11);
        add(0, 6'h05, 1, 1); add(0, 6'h05, 1, 2); add(0, 6'h05, 1, 11);
        // j, FETCH not ready for TMO-1 cycles, ready on the TMO-th
        for (int i = 0; i < TMO - 1; i++) add(0, 6'h02, 0, 1);
        add(0, 6'h02, 1, 1); add(0, 6'h02, 1, 2); add(0, 6'h02, 1, 12);
        // undefined opcode returns to FETCH
        add(0, 6'h3F, 1, 1); add(0, 6'h3F, 1, 2); add(0, 6'h3F, 1, 1);

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i].rst, vecs[i].op, vecs[i].rdy, vecs[i].st, $sformatf("vec%0d", i));

        // ---- FETCH timeout -> FAULT, sticky, cleared by reset ----
        apply(1, 6'h00, 1, 2, "tmo_f_rst");
        apply(0, 6'h00, 1, 0, "tmo_f_idle");
        for (int i = 0; i < TMO; i++) apply(0, 6'h00, 0, 1, $sformatf("tmo_f_wait%0d", i));
        apply(0, 6'h00, 0, 15, "tmo_f_fault0");
        apply(0, 6'h00, 1, 15, "tmo_f_fault1");
        apply(1, 6'h00, 1, 15, "tmo_f_rstin");
        apply(0, 6'h00, 1, 0, "tmo_f_idle2");

        // ---- MEMRD timeout ----
        apply(0, 6'h23, 1, 1, "tmo_r_fetch");
        apply(0, 6'h23, 1, 2, "tmo_r_dec");
        apply(0, 6'h23, 1, 3, "tmo_r_adr");
        for (int i = 0; i < TMO; i++) apply(0, 6'h23, 0, 4, $sformatf("tmo_r_wait%0d", i));
        apply(0, 6'h23, 1, 15, "tmo_r_fault");
        apply(1, 6'h23, 1, 15, "tmo_r_rstin");
        apply(0, 6'h23, 1, 0, "tmo_r_idle");

        // ---- reset during MEMWR abandons the store ----
        apply(0, 6'h2B, 1, 1, "rst_wr_fetch");
        apply(0, 6'h2B, 1, 2, "rst_wr_dec");
        apply(0, 6'h2B, 1, 3, "rst_wr_adr");
        apply(0, 6'h2B, 0, 6, "rst_wr_wait");
        apply(1, 6'h2B, 0, 6, "rst_wr_rstin");
        apply(0, 6'h2B, 1, 0, "rst_wr_idle");
        apply(0, 6'h2B, 1, 1, "rst_wr_fetch2");
        apply(0, 6'h2B, 1, 2, "rst_wr_dec2");
        apply(0, 6'h2B, 1, 3, "rst_wr_adr2");
        apply(0, 6'h2B, 1, 6, "rst_wr_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
